pipeline_stall_controller: RTL and testbench
============================================

PIPELINE_STALL_CONTROLLER -- requirements
Module: pipeline_stall_controller

Interface
REQ-001 SHALL have parameter WAIT_LIMIT, default 15, max consecutive SRAM wait cycles before timeout (range 1..255).
REQ-002 SHALL have parameter CNT_W, default 16, width of Stall_Count.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port Hazard_Detected  input  1  RAW/load-use hazard on the ID-stage instruction.
REQ-006 SHALL have port Branch_Taken  input  1  taken branch resolved in EXE.
REQ-007 SHALL have port MEM_Req  input  1  MEM-stage instruction is a load or store.
REQ-008 SHALL have port SRAM_Ready  input  1  data memory completes the current MEM access this cycle.
REQ-009 SHALL have port Freeze_PC  output  1  hold PC.
REQ-010 SHALL have port Freeze_IF_ID  output  1  hold IF/ID register.
REQ-011 SHALL have port Bubble_ID_EXE  output  1  zero ID/EXE control fields (hazard mux select).
REQ-012 SHALL have port Flush_IF_ID  output  1  clear IF/ID register.
REQ-013 SHALL have port Freeze_Back  output  1  hold ID/EXE, EXE/MEM and MEM/WB registers.
REQ-014 SHALL have port Stall_Count  output  CNT_W  saturating count of cycles with Freeze_PC=1.
REQ-015 SHALL have port Mem_Timeout  output  1  sticky SRAM timeout flag.

Function
REQ-016 SHALL implement FSM states RUN, MEM_WAIT, HALT; registered state, Mealy outputs (combinational from state and inputs, same-cycle effect).
REQ-017 SHALL in RUN apply priority: memory stall > branch > hazard > none.
REQ-018 SHALL in RUN with MEM_Req=1 and SRAM_Ready=0: Freeze_PC=Freeze_IF_ID=Freeze_Back=1, Bubble_ID_EXE=Flush_IF_ID=0; wait counter loads 1; next MEM_WAIT.
REQ-019 SHALL in RUN with no memory stall and Branch_Taken=1: Flush_IF_ID=1, Bubble_ID_EXE=1, freezes 0; Hazard_Detected ignored (wrong-path instruction).
REQ-020 SHALL in RUN with no memory stall, Branch_Taken=0, Hazard_Detected=1: Freeze_PC=Freeze_IF_ID=1, Bubble_ID_EXE=1, Flush_IF_ID=0, Freeze_Back=0.
REQ-021 SHALL in RUN otherwise drive all control outputs 0.
REQ-022 SHALL in MEM_WAIT with SRAM_Ready=0: all freezes 1, Bubble/Flush 0; wait counter increments; when counter already equals WAIT_LIMIT, set Mem_Timeout, next HALT instead of incrementing.
REQ-023 SHALL in MEM_WAIT with SRAM_Ready=1: release Freeze_Back, evaluate branch/hazard exactly as REQ-019..021, next RUN, wait counter cleared.
REQ-024 SHALL in HALT drive Freeze_PC=Freeze_IF_ID=Freeze_Back=1, Bubble/Flush 0, ignore all inputs; exit only by rst.
REQ-025 SHALL never assert Flush_IF_ID and Freeze_IF_ID in the same cycle.
REQ-026 SHALL increment Stall_Count each cycle Freeze_PC=1, saturating at all-ones (no wrap).
REQ-027 SHALL hold Mem_Timeout at 1 until rst once set.
REQ-028 SHALL treat SRAM_Ready=1 with MEM_Req=0 as don't-care in RUN.

Reset
REQ-029 SHALL on rst=1 at a clock edge: state RUN, wait counter 0, Stall_Count 0, Mem_Timeout 0, from any state including mid-MEM_WAIT and HALT.
REQ-030 SHALL during the rst=1 cycle drive all control outputs 0.

Verification
REQ-031 SHALL cover: Hazard_Detected=1 one cycle in RUN -> Freeze_PC=Freeze_IF_ID=Bubble_ID_EXE=1 that cycle, Stall_Count 0->1.
REQ-032 SHALL cover: Branch_Taken=1 with Hazard_Detected=1 -> Flush_IF_ID=1, Bubble_ID_EXE=1, Freeze_PC=0, Stall_Count unchanged.
REQ-033 SHALL cover: MEM_Req=1, SRAM_Ready low 3 cycles then high -> freezes high 3 cycles, released 4th, state RUN, Stall_Count=3.
REQ-034 SHALL cover: MEM_Req=1, SRAM_Ready stuck 0, WAIT_LIMIT=15 -> Mem_Timeout=1 after 15 wait cycles, HALT freezes persist.
REQ-035 SHALL cover: rst=1 in MEM_WAIT cycle 2 -> next cycle RUN, outputs 0, Stall_Count 0.
REQ-036 SHALL cover: CNT_W=4, 20 stall cycles -> Stall_Count holds 15.

Source files
------------

// File: rtl/pipeline_stall_controller.sv
// Pipeline hazard/stall controller: resolves memory stalls, taken-branch flushes and
// load-use bubbles into freeze/flush/bubble controls, with SRAM wait timeout and stall counting.
module pipeline_stall_controller #(
    parameter int unsigned WAIT_LIMIT = 15,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Hazard_Detected,
    input  logic             Branch_Taken,
    input  logic             MEM_Req,
    input  logic             SRAM_Ready,
    output logic             Freeze_PC,
    output logic             Freeze_IF_ID,
    output logic             Bubble_ID_EXE,
    output logic             Flush_IF_ID,
    output logic             Freeze_Back,
    output logic [CNT_W-1:0] Stall_Count,
    output logic             Mem_Timeout
);

    localparam int unsigned WCNT_W = 8;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [WCNT_W-1:0]   wait_q, wait_d;
    logic                tmo_q, tmo_d;
    logic [CNT_W-1:0]    cnt_q;
    logic                resolve;

    // State, wait counter and sticky timeout registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            wait_q  <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            tmo_q   <= tmo_d;
        end
    end

    // Next state and Mealy controls; resolve selects the branch/hazard decision.
    always_comb begin
        state_d       = state_q;
        wait_d        = wait_q;
        tmo_d         = tmo_q;
        resolve       = 1'b0;
        Freeze_PC     = 1'b0;
        Freeze_IF_ID  = 1'b0;
        Bubble_ID_EXE = 1'b0;
        Flush_IF_ID   = 1'b0;
        Freeze_Back   = 1'b0;
        if (!rst) begin
            case (state_q)
                RUN: begin
                    if (MEM_Req && !SRAM_Ready) begin
                        Freeze_PC    = 1'b1;
                        Freeze_IF_ID = 1'b1;
                        Freeze_Back  = 1'b1;
                        wait_d       = WCNT_W'(1);
                        state_d      = MEM_WAIT;
                    end else begin
                        resolve = 1'b1;
                    end
                end
                MEM_WAIT: begin
                    if (!SRAM_Ready) begin
                        Freeze_PC    = 1'b1;
                        Freeze_IF_ID = 1'b1;
                        Freeze_Back  = 1'b1;
                        if (wait_q == WCNT_W'(WAIT_LIMIT)) begin
                            tmo_d   = 1'b1;
                            state_d = HALT;
                        end else begin
                            wait_d = wait_q + WCNT_W'(1);
                        end
                    end else begin
                        resolve = 1'b1;
                        wait_d  = '0;
                        state_d = RUN;
                    end
                end
                HALT: begin
                    Freeze_PC    = 1'b1;
                    Freeze_IF_ID = 1'b1;
                    Freeze_Back  = 1'b1;
                end
                default: state_d = RUN;
            endcase

            // A taken branch squashes the wrong-path ID instruction, so its hazard is moot.
            if (resolve) begin
                if (Branch_Taken) begin
                    Flush_IF_ID   = 1'b1;
                    Bubble_ID_EXE = 1'b1;
                end else if (Hazard_Detected) begin
                    Freeze_PC     = 1'b1;
                    Freeze_IF_ID  = 1'b1;
                    Bubble_ID_EXE = 1'b1;
                end
            end
        end
    end

    // Saturating count of PC-frozen cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (Freeze_PC && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign Stall_Count = cnt_q;
    assign Mem_Timeout = tmo_q;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Scoreboard bench: a driver queues hand-computed expectations per cycle; a monitor
// pops and compares them mid-cycle against the default and a 4-bit-counter instance.
module tb_pipeline_stall_controller;

    typedef struct packed {
        logic [4:0]  ctrl;   // {Freeze_PC, Freeze_IF_ID, Bubble_ID_EXE, Flush_IF_ID, Freeze_Back}
        logic [15:0] cnt;
        logic        tmo;
        logic [3:0]  c2;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, hz, br, mr, sr, h2;
    logic        fpc, fif, bub, flu, fbk, tmo;
    logic [15:0] cnt;
    logic        fpc2, fif2, bub2, flu2, fbk2, tmo2;
    logic [3:0]  cnt2;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    localparam logic [4:0] C_IDLE = 5'b00000;
    localparam logic [4:0] C_HAZ  = 5'b11100;
    localparam logic [4:0] C_BR   = 5'b00110;
    localparam logic [4:0] C_MEM  = 5'b11001;

    always #5 clk = ~clk;

    pipeline_stall_controller #(.WAIT_LIMIT(15), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .Hazard_Detected(hz), .Branch_Taken(br),
        .MEM_Req(mr), .SRAM_Ready(sr), .Freeze_PC(fpc), .Freeze_IF_ID(fif),
        .Bubble_ID_EXE(bub), .Flush_IF_ID(flu), .Freeze_Back(fbk),
        .Stall_Count(cnt), .Mem_Timeout(tmo)
    );

    pipeline_stall_controller #(.WAIT_LIMIT(15), .CNT_W(4)) dut2 (
        .clk(clk), .rst(rst), .Hazard_Detected(h2), .Branch_Taken(1'b0),
        .MEM_Req(1'b0), .SRAM_Ready(1'b0), .Freeze_PC(fpc2), .Freeze_IF_ID(fif2),
        .Bubble_ID_EXE(bub2), .Flush_IF_ID(flu2), .Freeze_Back(fbk2),
        .Stall_Count(cnt2), .Mem_Timeout(tmo2)
    );

    task automatic step(input logic r, input logic h, input logic b, input logic m,
                        input logic s, input logic hh, input logic [4:0] ctrl,
                        input int ecnt, input logic etmo, input int ec2);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; hz = h; br = b; mr = m; sr = s; h2 = hh;
        e.ctrl = ctrl;
        e.cnt  = 16'(ecnt);
        e.tmo  = etmo;
        e.c2   = 4'(ec2);
        q.push_back(e);
    endtask

    // Monitor: compare mid-cycle, after inputs settle and before the next edge.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            logic [4:0] act;
            e   = q.pop_front();
            act = {fpc, fif, bub, flu, fbk};
            total++;
            if (act !== e.ctrl) begin
                bad++;
                $display("FAIL ctrl t=%0t: got %b want %b", $time, act, e.ctrl);
            end
            total++;
            if (cnt !== e.cnt) begin
                bad++;
                $display("FAIL stall_count t=%0t: got %0d want %0d", $time, cnt, e.cnt);
            end
            total++;
            if (tmo !== e.tmo) begin
                bad++;
                $display("FAIL mem_timeout t=%0t: got %b want %b", $time, tmo, e.tmo);
            end
            total++;
            if (cnt2 !== e.c2) begin
                bad++;
                $display("FAIL stall_count_w4 t=%0t: got %0d want %0d", $time, cnt2, e.c2);
            end
            total++;
            if (flu && fif) begin
                bad++;
                $display("FAIL flush_freeze_excl t=%0t: got both 1 want not both", $time);
            end
        end
    end

    initial begin
        int n;
        rst = 1'b1; hz = 1'b0; br = 1'b0; mr = 1'b0; sr = 1'b0; h2 = 1'b0;
        // r h b m s h2  ctrl   cnt tmo c2
        step(1,0,0,0,0,0, C_IDLE, 0, 0, 0);
        step(0,0,0,0,0,0, C_IDLE, 0, 0, 0);
        step(0,0,0,0,1,0, C_IDLE, 0, 0, 0);   // SRAM_Ready without MEM_Req
        step(0,1,0,0,0,0, C_HAZ,  0, 0, 0);   // load-use hazard
        step(0,0,0,0,0,0, C_IDLE, 1, 0, 0);
        step(0,1,1,0,0,0, C_BR,   1, 0, 0);   // branch beats hazard
        step(0,0,0,0,0,0, C_IDLE, 1, 0, 0);
        step(0,0,1,0,0,0, C_BR,   1, 0, 0);
        step(1,0,0,0,0,0, C_IDLE, 1, 0, 0);
        // 3 wait cycles then ready
        step(0,0,0,1,0,0, C_MEM,  0, 0, 0);
        step(0,0,0,1,0,0, C_MEM,  1, 0, 0);
        step(0,0,0,1,0,0, C_MEM,  2, 0, 0);
        step(0,0,0,1,1,0, C_IDLE, 3, 0, 0);
        step(0,0,0,0,0,0, C_IDLE, 3, 0, 0);
        // release with hazard, memory stall beats branch, release with branch
        step(0,0,0,1,0,0, C_MEM,  3, 0, 0);
        step(0,1,0,1,1,0, C_HAZ,  4, 0, 0);
        step(0,0,0,0,0,0, C_IDLE, 5, 0, 0);
        step(0,1,1,1,0,0, C_MEM,  5, 0, 0);
        step(0,0,1,1,1,0, C_BR,   6, 0, 0);
        step(0,0,0,0,0,0, C_IDLE, 6, 0, 0);
        // reset during MEM_WAIT
        step(0,0,0,1,0,0, C_MEM,  6, 0, 0);
        step(1,0,0,1,0,0, C_IDLE, 7, 0, 0);
        step(0,0,0,0,0,0, C_IDLE, 0, 0, 0);
        // SRAM stuck: timeout after the wait limit, HALT ignores inputs
        for (int k = 0; k < 20; k++) begin
            n = k;
            step(0, 0, (k >= 17), 1, (k >= 17), 0, C_MEM, n, (k >= 16), 0);
        end
        step(1,0,0,0,0,0, C_IDLE, 20, 1, 0);
        step(0,0,0,0,0,0, C_IDLE, 0,  0, 0);
        // 4-bit counter saturation
        for (int k = 0; k < 20; k++) begin
            n = (k > 15) ? 15 : k;
            step(0,0,0,0,0,1, C_IDLE, 0, 0, n);
        end
        step(0,0,0,0,0,0, C_IDLE, 0, 0, 15);
        step(0,0,0,0,0,0, C_IDLE, 0, 0, 15);

        n = 0;
        while (q.size() > 0 && n < 10) begin
            @(posedge clk);
            n++;
        end
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
